// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with wrap or saturate mode, tc and wrap flags.
// Define COUNTER_LOAD_EN to add the synchronous clamped parallel load (load, load_val).
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t,
  input  logic             up,
  input  logic             down,
`ifdef COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             dir
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_dir;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_up;
  logic             w_dn;
  logic             w_at_max;
  logic             w_at_zero;
`ifdef COUNTER_LOAD_EN
  assign w_load     = load;
  assign w_load_val = load_val;
`else
  assign w_load     = 1'b0;
  assign w_load_val = '0;
`endif
  // up and down together is a hold, not an up step
  assign w_up      = t & up & ~down;
  assign w_dn      = t & down & ~up;
  assign w_at_max  = r_q == MAX;
  assign w_at_zero = r_q == '0;
  assign tc   = reset_n & ~w_load & ((w_up & w_at_max) | (w_dn & w_at_zero));
  assign q    = r_q;
  assign wrap = r_wrap;
  assign dir  = r_dir;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_dir  <= 1'b1;
    end else if (w_load) begin
      r_q    <= (w_load_val > MAX) ? MAX : w_load_val;
      r_wrap <= 1'b0;
    end else if (w_up) begin
      r_q    <= w_at_max ? ((SATURATE != 0) ? r_q : '0) : r_q + 1'b1;
      r_wrap <= w_at_max;
      r_dir  <= 1'b1;
    end else if (w_dn) begin
      r_q    <= w_at_zero ? ((SATURATE != 0) ? r_q : MAX) : r_q - 1'b1;
      r_wrap <= w_at_zero;
      r_dir  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed vectors for a wrapping and a saturating counter (MODULUS=10),
// expected values queued at issue time and checked by an independent monitor.
module tb_param_updown_counter;
  logic       clk = 1'b0;
  logic       rn0 = 1'b0, t0 = 1'b0, u0 = 1'b0, d0 = 1'b0, ld0 = 1'b0;
  logic [3:0] lv0 = '0;
  logic       rn1 = 1'b0, t1 = 1'b0, u1 = 1'b0, d1 = 1'b0, ld1 = 1'b0;
  logic [3:0] lv1 = '0;
  logic [3:0] q0, q1;
  logic       tc0, tc1, w0, w1, dr0, dr1;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    bit         sel;
    bit         rn, t, u, d, ld;
    logic [3:0] lv;
    logic [3:0] q;
    bit         w, dr, tc;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] q;
    bit         w, dr, tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (
    .clk(clk), .reset_n(rn0), .t(t0), .up(u0), .down(d0),
`ifdef COUNTER_LOAD_EN
    .load(ld0), .load_val(lv0),
`endif
    .q(q0), .tc(tc0), .wrap(w0), .dir(dr0)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (
    .clk(clk), .reset_n(rn1), .t(t1), .up(u1), .down(d1),
`ifdef COUNTER_LOAD_EN
    .load(ld1), .load_val(lv1),
`endif
    .q(q1), .tc(tc1), .wrap(w1), .dir(dr1)
  );

  task automatic add(input bit sel, input bit rn, input bit t, input bit u, input bit d,
                     input bit ld, input logic [3:0] lv, input logic [3:0] q,
                     input bit w, input bit dr, input bit tc);
    vec_t v;
    v = '{sel, rn, t, u, d, ld, lv, q, w, dr, tc};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input exp_t e, input logic [3:0] q,
                       input logic w, input logic dr, input logic tc);
    total++;
    if (q !== e.q || w !== e.w || dr !== e.dr || tc !== e.tc) begin
      bad++;
      $display("FAIL %s vec%0d: got q=%0d wrap=%b dir=%b tc=%b, want q=%0d wrap=%b dir=%b tc=%b",
               name, e.id, q, w, dr, tc, e.q, e.w, e.dr, e.tc);
    end
  endtask

  // monitor: samples 1 time unit after each rising edge, inputs of that edge still applied
  always @(posedge clk) begin
    #1;
    if (sb0.size() > 0) check("wrapctr", sb0.pop_front(), q0, w0, dr0, tc0);
    if (sb1.size() > 0) check("satctr", sb1.pop_front(), q1, w1, dr1, tc1);
  end

  initial begin
    // wrapping counter: reset held with t=up=1
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 1, 0, 0, 0, 4'(i), 0, 1, i == 9);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 9, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 8, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 7, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 6, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1, 0, 0, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, 0, 0, 5, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 6, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0, 9, 1, 0, 0);
`ifdef COUNTER_LOAD_EN
    add(0, 1, 1, 1, 0, 1, 7, 7, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 13, 9, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 9, 9, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 1, 5, 0, 0, 1, 0);
`endif
    // saturating counter
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 8; i++) add(1, 1, 1, 1, 0, 0, 0, 4'(i), 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 9, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, 9, 1, 1, 1);
    add(1, 1, 1, 1, 0, 0, 0, 9, 1, 1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 9, 0, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      exp_t e;
      v = vecs[i];
      @(negedge clk);
      e = '{i, v.q, v.w, v.dr, v.tc};
      if (v.sel) begin
        {rn1, t1, u1, d1, ld1, lv1} = {v.rn, v.t, v.u, v.d, v.ld, v.lv};
        {rn0, t0, u0, d0, ld0} = 5'b10000;
        sb1.push_back(e);
      end else begin
        {rn0, t0, u0, d0, ld0, lv0} = {v.rn, v.t, v.u, v.d, v.ld, v.lv};
        {rn1, t1, u1, d1, ld1} = 5'b10000;
        sb0.push_back(e);
      end
    end
    @(negedge clk);
    @(negedge clk);
    if (sb0.size() + sb1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb0.size() + sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
